// File: rtl/thermo_decoder_driver.sv
// Thermometer-code decoder and phased eFlash input driver.
// One request is decoded into one (rbr) or two (parallel) timed drive phases.
module thermo_decoder_driver #(
    parameter int PULSE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       mode_i,
    input  logic [6:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] eflash_input_o,
    output logic       drv_en_o,
    output logic       drv_sel_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE_1,
        DRIVE_2,
        DONE
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(PULSE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic [6:0] data_q, data_d;
    logic       err_q, err_d;

    logic [7:0] code1, code2;
    logic       req_legal;

    function automatic logic [7:0] therm(input logic [3:0] n);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            t[7-i] = (i < int'(n));
        end
        return t;
    endfunction

    function automatic logic rbr_legal(input logic [3:0] v);
        return (v <= 4'd4) || (v == 4'd6) || (v == 4'd9);
    endfunction

    assign req_legal = mode_i ? (data_i <= 7'd72)
                              : rbr_legal(data_i[3:0]);

    // Codes come only from the captured request so the live bus can move freely.
    always_comb begin
        code1 = 8'h00;
        code2 = 8'h00;
        if (mode_q) begin
            if (data_q == 7'd72) begin
                code1 = 8'hFF;
                code2 = 8'hFF;
            end else begin
                code1 = therm(data_q[6:3]);
                code2 = therm({1'b0, data_q[2:0]});
            end
        end else begin
            case (data_q[3:0])
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4:
                    code1 = therm(4'd8 - data_q[3:0]);
                4'd6:    code1 = therm(4'd2);
                default: code1 = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        data_d         = data_q;
        err_d          = err_q;
        ready_o        = 1'b0;
        drv_en_o       = 1'b0;
        drv_sel_o      = 1'b0;
        eflash_input_o = 8'h00;
        done_o         = 1'b0;
        err_o          = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    mode_d  = mode_i;
                    data_d  = data_i;
                    cnt_d   = 8'd0;
                    err_d   = !req_legal;
                    state_d = req_legal ? DRIVE_1 : DONE;
                end
            end
            DRIVE_1: begin
                drv_en_o       = 1'b1;
                eflash_input_o = code1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = mode_q ? DRIVE_2 : DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DRIVE_2: begin
                drv_en_o       = 1'b1;
                drv_sel_o      = 1'b1;
                eflash_input_o = code2;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            mode_q  <= 1'b0;
            data_q  <= 7'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule
